// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial add/subtract unit.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for addsub_serial; WIDTH must match the unit's WIDTH.
interface addsub_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, result, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, result, cout, ovf, busy
    );
endinterface

// File: rtl/addsub_digit.sv
// Combinational DIGIT-wide ripple adder slice used once per serial step.
module addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract: DIGIT bits per clock, WIDTH/DIGIT cycles per operation.
// Optional result saturation on signed overflow when ADDSUB_SAT_EN is defined.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic            clk,
    input logic            rst_n,
    addsub_serial_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt, b_eff;
    logic [WIDTH-1:0] res_q, final_res;
    logic             carry, a_msb, b_msb, cout_q, ovf_q, raw_ovf;
    logic [CW-1:0]    count;
    logic [DIGIT-1:0] sum_d;
    logic             co_d;
    logic             accept, last;

    assign b_eff  = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    assign accept = (state == IDLE) && bus.in_valid;
    assign last   = (state == RUN) && (count == CW'(STEPS - 1));

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x  (a_sh[DIGIT-1:0]),
        .y  (b_sh[DIGIT-1:0]),
        .ci (carry),
        .s  (sum_d),
        .co (co_d)
    );

    // New sum digit enters from the MSB side so the last step leaves bit 0 at the bottom.
    assign acc_nxt = (acc >> DIGIT) | (WIDTH'(sum_d) << (WIDTH - DIGIT));
    assign raw_ovf = (a_msb == b_msb) && (acc_nxt[WIDTH-1] != a_msb);

    always_comb begin
        final_res = acc_nxt;
`ifdef ADDSUB_SAT_EN
        if (raw_ovf)
            final_res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = rst_n && (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state == RUN) || (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            count  <= '0;
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= b_eff;
            carry <= (bus.op == OP_SUB) ? ~bus.cin : bus.cin;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= b_eff[WIDTH-1];
            count <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            acc   <= acc_nxt;
            carry <= co_d;
            count <= count + CW'(1);
            if (last) begin
                res_q  <= final_res;
                cout_q <= co_d;
                ovf_q  <= raw_ovf;
            end
        end
    end

    assign bus.result = res_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: 8-bit/DIGIT=1 against an arithmetic model, plus 16-bit/DIGIT=4.
module tb_addsub_serial;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    addsub_serial_if #(.WIDTH(8))  bus8 ();
    addsub_serial_if #(.WIDTH(16)) bus16 ();

    addsub_serial #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    addsub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] res;
        logic       cout;
        logic       ovf;
    } exp_t;

    // Plain integer arithmetic: unsigned view gives carry/borrow, signed view gives overflow.
    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b,
                                    input logic cin, input logic op);
        int ua, ub, sa, sb, ci, u, s;
        exp_t e;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = int'(cin);
        if (!op) begin
            u = ua + ub + ci;
            s = sa + sb + ci;
            e.cout = (u > 255);
        end else begin
            u = ua - ub - ci;
            s = sa - sb - ci;
            e.cout = (u >= 0);
        end
        e.res = u[7:0];
        e.ovf = (s > 127) || (s < -128);
`ifdef ADDSUB_SAT_EN
        if (e.ovf) e.res = (sa < 0) ? 8'h80 : 8'h7F;
`endif
        return e;
    endfunction

    exp_t m_pend = '0;
    exp_t m_out  = '0;
    logic m_busy = 1'b0;
    int   m_age  = 0;

    // Model: result appears 8 edges after acceptance and stays until consumed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            m_out  <= '0;
        end else if (m_busy) begin
            if (m_age == 8) begin
                if (bus8.out_ready) m_busy <= 1'b0;
            end else begin
                m_age <= m_age + 1;
                if (m_age == 7) m_out <= m_pend;
            end
        end else if (bus8.in_valid) begin
            m_busy <= 1'b1;
            m_age  <= 0;
            m_pend <= model8(bus8.a, bus8.b, bus8.cin, bus8.op);
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  bus8.in_ready,  rst_n && !m_busy);
        chk("out_valid", bus8.out_valid, m_busy && (m_age == 8));
        chk("busy",      bus8.busy,      m_busy);
        chk("result",    bus8.result,    m_out.res);
        chk("cout",      bus8.cout,      m_out.cout);
        chk("ovf",       bus8.ovf,       m_out.ovf);
    end

    task automatic txn8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic top,
                        input logic [7:0] er, input logic ec, input logic eo,
                        input string tag, input logic consume);
        int w, lat;
        w = 0;
        while (!bus8.in_ready && w < 50) begin @(negedge clk); w++; end
        chk({tag, "_ready"}, bus8.in_ready, 1);
        bus8.a = ta; bus8.b = tb; bus8.cin = tc; bus8.op = top; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        bus8.a = ~ta; bus8.b = ~tb; bus8.cin = ~tc; bus8.op = ~top;
        lat = 0;
        while (!bus8.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_result"},  bus8.result, er);
        chk({tag, "_cout"},    bus8.cout, ec);
        chk({tag, "_ovf"},     bus8.ovf, eo);
        if (consume) begin
            bus8.out_ready = 1'b1;
            @(posedge clk); #1;
            bus8.out_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic txn16(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic top,
                         input logic [15:0] er, input logic ec, input logic eo, input string tag);
        int w, lat;
        w = 0;
        while (!bus16.in_ready && w < 50) begin @(negedge clk); w++; end
        chk({tag, "_ready"}, bus16.in_ready, 1);
        bus16.a = ta; bus16.b = tb; bus16.cin = tc; bus16.op = top; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        bus16.a = ~ta; bus16.b = ~tb;
        lat = 0;
        while (!bus16.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_result"},  bus16.result, er);
        chk({tag, "_cout"},    bus16.cout, ec);
        chk({tag, "_ovf"},     bus16.ovf, eo);
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       cin, op;
        logic [7:0] res;
        logic       cout, ovf;
        string      tag;
    } vec_t;

    localparam logic [7:0] OVF_RES =
`ifdef ADDSUB_SAT_EN
        8'h7F;
`else
        8'h80;
`endif
    localparam logic [15:0] OVF16_RES =
`ifdef ADDSUB_SAT_EN
        16'h8000;
`else
        16'h7FFF;
`endif

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h37, 8'h05, 1'b1, 1'b0, 8'h3D, 1'b0, 1'b0, "add_cin"};
        vecs[1] = '{8'h37, 8'h05, 1'b0, 1'b1, 8'h32, 1'b1, 1'b0, "sub"};
        vecs[2] = '{8'h05, 8'h06, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, "sub_borrow"};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "add_wrap"};
        vecs[4] = '{8'h70, 8'h10, 1'b0, 1'b0, OVF_RES, 1'b0, 1'b1, "add_ovf"};

        {bus8.in_valid, bus8.a, bus8.b, bus8.cin, bus8.op, bus8.out_ready} = '0;
        {bus16.in_valid, bus16.a, bus16.b, bus16.cin, bus16.op, bus16.out_ready} = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready16",  bus16.in_ready, 0);
        chk("rst_out_valid16", bus16.out_valid, 0);
        chk("rst_result16",    bus16.result, 0);
        chk("rst_busy16",      bus16.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            txn8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op,
                 vecs[i].res, vecs[i].cout, vecs[i].ovf, vecs[i].tag, 1'b1);

        // Hold the result under backpressure while ignored operands are offered.
        txn8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, "bp", 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus8.a = 8'h11; bus8.b = 8'h22; bus8.in_valid = 1'b1;
            @(posedge clk); #1;
            bus8.in_valid = 1'b0;
            chk("bp_out_valid", bus8.out_valid, 1);
            chk("bp_in_ready",  bus8.in_ready, 0);
            chk("bp_result",    bus8.result, 8'h46);
        end
        @(negedge clk);
        bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b0; bus8.op = 1'b0;
        bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        chk("dual_out_valid", bus8.out_valid, 0);
        chk("dual_in_ready",  bus8.in_ready, 1);
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        chk("dual_busy", bus8.busy, 1);
        repeat (8) @(posedge clk);
        #1;
        chk("dual_valid",  bus8.out_valid, 1);
        chk("dual_result", bus8.result, 8'h03);
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        @(negedge clk);

        // Abort in the middle of RUN.
        bus8.a = 8'h55; bus8.b = 8'h22; bus8.cin = 1'b0; bus8.op = 1'b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus8.out_valid, 0);
        chk("abort_busy",      bus8.busy, 0);
        chk("abort_in_ready",  bus8.in_ready, 0);
        chk("abort_result",    bus8.result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn8(8'h6F, 8'h07, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0, "post_reset", 1'b1);

        txn16(16'h8000, 16'h0001, 1'b0, 1'b1, OVF16_RES, 1'b1, 1'b1, "w16_sub_ovf");
        txn16(16'h1234, 16'h0FED, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0, "w16_add");
        txn16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "w16_wrap");

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
